perip_uart: RTL and testbench



---
 rtl/perip_uart_pkg.sv | 38 +++
 rtl/perip_uart_tx_fifo.sv | 44 ++++
 rtl/perip_uart.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_perip_uart.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/perip_uart_pkg.sv
// Shared constants and types for the memory-mapped UART peripheral.
package perip_uart_pkg;

  // UART window on the peripheral data bus, next to ram/term/kbd/perip_time.
  localparam logic [31:0] UART_ADDR_L = 32'hFFFF_FF40;
  localparam logic [31:0] UART_ADDR_R = 32'hFFFF_FF4F;

  // Window-relative register offsets (only bits [3:2] are decoded).
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_RXDATA = 4'h4;
  localparam logic [3:0] UART_STATUS = 4'h8;
  localparam logic [3:0] UART_DIV    = 4'hC;

  // STATUS register bit positions.
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_FRAME_ERR  = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // RX_WAIT holds off after a framing error until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/perip_uart_tx_fifo.sv
// Byte-wide circular TX FIFO; pointers carry one extra wrap bit.
module perip_uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a push into a full FIFO is silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/perip_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, single-entry RX holding register.
module perip_uart
  import perip_uart_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        rw,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

  // Bus decode
  logic [3:0] off_s;
  logic       wr_tx_s, wr_status_s, wr_div_s, rx_pop_s, unused_s;
  assign off_s       = {addr[3:2], 2'b00};
  assign wr_tx_s     = ena & rw & (off_s == UART_TXDATA);
  assign wr_status_s = ena & rw & (off_s == UART_STATUS);
  assign wr_div_s    = ena & rw & (off_s == UART_DIV);
  assign rx_pop_s    = ena & ~rw & (off_s == UART_RXDATA);
  assign unused_s    = ^{addr[31:4], addr[1:0], wdata[31:16]};

  // Register file state
  logic [15:0] div_r;
  logic [7:0]  rx_byte_r;
  logic        rx_valid_r, rx_overrun_r, frame_err_r;

  // TX path state
  tx_state_t   tx_state_r, tx_state_nxt_s;
  logic [15:0] tx_cnt_r, tx_cnt_nxt_s;
  logic [2:0]  tx_bit_r, tx_bit_nxt_s;
  logic [7:0]  tx_shift_r, tx_shift_nxt_s;
  logic        tx_line_r, tx_line_nxt_s;
  logic        fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_rdata_s;

  // RX path state
  rx_state_t   rx_state_r, rx_state_nxt_s;
  logic [15:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [2:0]  rx_bit_r, rx_bit_nxt_s;
  logic [7:0]  rx_shift_r, rx_shift_nxt_s;
  logic        rx_meta_r, rx_sync_r;
  logic        rx_done_s, frame_set_s, rx_load_s, ovr_set_s;

  perip_uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx_s),
    .wdata (wdata[7:0]),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign uart_tx = tx_line_r;

  // TX next-state: each state lasts div_r cycles; the counter reloads at every bit boundary.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    tx_bit_nxt_s   = tx_bit_r;
    tx_shift_nxt_s = tx_shift_r;
    tx_line_nxt_s  = tx_line_r;
    fifo_pop_s     = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s     = 1'b1;
          tx_shift_nxt_s = fifo_rdata_s;
          tx_line_nxt_s  = 1'b0;
          tx_cnt_nxt_s   = div_r - 16'd1;
          tx_state_nxt_s = TX_START;
        end else begin
          tx_line_nxt_s  = 1'b1;
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == 16'd0) begin
          tx_line_nxt_s  = tx_shift_r[0];
          tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
          tx_bit_nxt_s   = 3'd0;
          tx_cnt_nxt_s   = div_r - 16'd1;
          tx_state_nxt_s = TX_DATA;
        end else begin
          tx_cnt_nxt_s   = tx_cnt_r - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == 16'd0) begin
          tx_cnt_nxt_s = div_r - 16'd1;
          if (tx_bit_r == 3'd7) begin
            tx_line_nxt_s  = 1'b1;
            tx_state_nxt_s = TX_STOP;
          end else begin
            tx_line_nxt_s  = tx_shift_r[0];
            tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
            tx_bit_nxt_s   = tx_bit_r + 3'd1;
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == 16'd0) begin
          // Chain straight into the next start bit so frames leave no idle gap.
          if (!fifo_empty_s) begin
            fifo_pop_s     = 1'b1;
            tx_shift_nxt_s = fifo_rdata_s;
            tx_line_nxt_s  = 1'b0;
            tx_cnt_nxt_s   = div_r - 16'd1;
            tx_state_nxt_s = TX_START;
          end else begin
            tx_state_nxt_s = TX_IDLE;
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      default: begin
        tx_line_nxt_s  = 1'b1;
        tx_state_nxt_s = TX_IDLE;
      end
    endcase
  end

  // TX state register; reset forces the line high on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      tx_line_r  <= tx_line_nxt_s;
    end
  end

  // Two-flop synchroniser for the asynchronous serial input, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // RX next-state: half-bit wait to centre the samples, then one sample per bit period.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    rx_bit_nxt_s   = rx_bit_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_done_s      = 1'b0;
    frame_set_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rx_sync_r) begin
          rx_cnt_nxt_s   = {1'b0, div_r[15:1]} - 16'd1;
          rx_state_nxt_s = RX_START;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == 16'd0) begin
          if (rx_sync_r) begin
            rx_state_nxt_s = RX_IDLE;
          end else begin
            rx_cnt_nxt_s   = div_r - 16'd1;
            rx_bit_nxt_s   = 3'd0;
            rx_state_nxt_s = RX_DATA;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == 16'd0) begin
          rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_cnt_nxt_s   = div_r - 16'd1;
          if (rx_bit_r == 3'd7) begin
            rx_state_nxt_s = RX_STOP;
          end else begin
            rx_bit_nxt_s   = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == 16'd0) begin
          if (rx_sync_r) begin
            rx_done_s      = 1'b1;
            rx_state_nxt_s = RX_IDLE;
          end else begin
            frame_set_s    = 1'b1;
            rx_state_nxt_s = RX_WAIT;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_WAIT: begin
        if (rx_sync_r) begin
          rx_state_nxt_s = RX_IDLE;
        end else begin
          rx_state_nxt_s = RX_WAIT;
        end
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_state_r <= rx_state_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      rx_bit_r   <= rx_bit_nxt_s;
      rx_shift_r <= rx_shift_nxt_s;
    end
  end

  // A good frame arriving in the same cycle as a pop replaces the held byte instead of overrunning.
  assign rx_load_s = rx_done_s & (~rx_valid_r | rx_pop_s);
  assign ovr_set_s = rx_done_s & rx_valid_r & ~rx_pop_s;

  // Holding register, sticky flags (set beats clear) and baud divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_r    <= 8'd0;
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
      frame_err_r  <= 1'b0;
      div_r        <= DIV_RESET;
    end else begin
      if (rx_load_s) begin
        rx_byte_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_pop_s) begin
        rx_valid_r <= 1'b0;
      end
      if (ovr_set_s) begin
        rx_overrun_r <= 1'b1;
      end else if (wr_status_s && wdata[ST_RX_OVERRUN]) begin
        rx_overrun_r <= 1'b0;
      end
      if (frame_set_s) begin
        frame_err_r <= 1'b1;
      end else if (wr_status_s && wdata[ST_FRAME_ERR]) begin
        frame_err_r <= 1'b0;
      end
      if (wr_div_s) begin
        div_r <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      end
    end
  end

  // Read mux; unselected or unused locations read as zero.
  always_comb begin
    rdata = 32'd0;
    if (ena) begin
      case (off_s)
        UART_TXDATA: rdata = 32'd0;
        UART_RXDATA: rdata = {23'd0, rx_valid_r, rx_byte_r};
        UART_STATUS: begin
          rdata[ST_TX_FULL]    = fifo_full_s;
          rdata[ST_TX_EMPTY]   = fifo_empty_s;
          rdata[ST_RX_VALID]   = rx_valid_r;
          rdata[ST_RX_OVERRUN] = rx_overrun_r;
          rdata[ST_TX_BUSY]    = (tx_state_r != TX_IDLE);
          rdata[ST_FRAME_ERR]  = frame_err_r;
        end
        UART_DIV:    rdata = {16'd0, div_r};
        default:     rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_perip_uart.sv
// Directed self-checking bench for perip_uart at default parameters.
module tb_perip_uart;
  logic        clk = 1'b0;
  logic        rst, ena, rw, uart_rx, uart_tx;
  logic [31:0] addr, wdata, rdata, rd;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          mism;
  logic [7:0]  fifo_bytes [17];

  perip_uart dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .rw      (rw),
    .addr    (addr),
    .rdata   (rdata),
    .wdata   (wdata),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge; each spans one rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; rw = 1'b1; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0; rw = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rw = 1'b0; ena = 1'b1;
    #1 rd = rdata;
    chk(tag, rd, exp);
    @(negedge clk);
    ena = 1'b0;
  endtask

  // Drive one 8N1 frame at 8 clocks per bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (8) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (8) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Expected line level p cycles into a frame of byte b at div cycles per bit.
  function automatic logic fbit(input logic [7:0] b, input int p, input int div);
    if (p < div) return 1'b0;
    else if (p < 9 * div) return b[(p - div) / div];
    else return 1'b1;
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b0; rw = 1'b0; addr = 32'd0; wdata = 32'd0; uart_rx = 1'b1;
    for (int j = 0; j < 17; j++) fifo_bytes[j] = 8'((j * 29 + 7) & 255);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset_tx_idle", {31'd0, uart_tx}, 32'd1);
    addr = 32'h8;
    #1 chk("rdata_zero_when_unselected", rdata, 32'd0);
    @(negedge clk);
    read_chk("reset_status", 32'h8, 32'h0000_0002);
    read_chk("reset_div", 32'hC, 32'd434);
    read_chk("txdata_reads_zero", 32'h0, 32'd0);
    bus_write(32'hC, 32'd1);
    read_chk("div_floor_2", 32'hC, 32'd2);
    bus_write(32'hC, 32'd4);
    read_chk("div_write_4", 32'hC, 32'd4);

    // Single frame 0x55 at DIV=4
    bus_write(32'h0, 32'h55);
    chk("tx_high_before_pop", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    chk("start_bit_after_pop", {31'd0, uart_tx}, 32'd0);
    mism = 0;
    for (int p = 0; p < 40; p++) begin
      if (uart_tx !== fbit(8'h55, p, 4)) mism++;
      @(negedge clk);
    end
    chk("frame_55_mismatches", 32'(mism), 32'd0);
    read_chk("idle_after_frame", 32'h8, 32'h0000_0002);

    // 17 back-to-back pushes: first goes to the shifter, remaining 16 fill the FIFO
    for (int j = 0; j < 17; j++) bus_write(32'h0, {24'd0, fifo_bytes[j]});
    read_chk("fifo_full_busy", 32'h8, 32'h0000_0011);
    bus_write(32'h0, 32'h0000_00EE);
    read_chk("fifo_full_after_drop", 32'h8, 32'h0000_0011);
    for (int f = 0; f < 17; f++) begin
      mism = 0;
      for (int p = 0; p < 40; p++) begin
        if (f * 40 + p >= 18) begin
          if (uart_tx !== fbit(fifo_bytes[f], p, 4)) mism++;
          @(negedge clk);
        end
      end
      chk($sformatf("fifo_frame_%0d", f), 32'(mism), 32'd0);
    end
    read_chk("fifo_drained_no_extra", 32'h8, 32'h0000_0002);

    // RX at DIV=8
    bus_write(32'hC, 32'd8);
    send_rx(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    read_chk("rx_valid_set", 32'h8, 32'h0000_0006);
    read_chk("rxdata_a3_pop", 32'h4, 32'h0000_01A3);
    read_chk("rxdata_after_pop", 32'h4, 32'h0000_00A3);

    // Overrun: second byte discarded
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    read_chk("rxdata_keeps_first", 32'h4, 32'h0000_0111);
    read_chk("overrun_set", 32'h8, 32'h0000_000A);
    bus_write(32'h8, 32'h0000_0008);
    read_chk("overrun_cleared", 32'h8, 32'h0000_0002);

    // Framing error
    send_rx(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    read_chk("frame_err_set", 32'h8, 32'h0000_0022);
    read_chk("frame_err_no_load", 32'h4, 32'h0000_0011);
    bus_write(32'h8, 32'h0000_0020);
    read_chk("frame_err_cleared", 32'h8, 32'h0000_0002);

    // Two-cycle glitch is rejected, then a good frame still lands
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    read_chk("glitch_status", 32'h8, 32'h0000_0002);
    read_chk("glitch_rxdata", 32'h4, 32'h0000_0011);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    read_chk("rx_after_glitch", 32'h4, 32'h0000_013C);

    // Reset mid-frame
    bus_write(32'h0, 32'h0000_0000);
    repeat (10) @(negedge clk);
    chk("tx_low_mid_frame", {31'd0, uart_tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_abort_tx_high", {31'd0, uart_tx}, 32'd1);
    rst = 1'b0;
    read_chk("reset_abort_status", 32'h8, 32'h0000_0002);
    read_chk("reset_abort_div", 32'hC, 32'd434);
    repeat (4) @(negedge clk);
    chk("tx_stays_high", {31'd0, uart_tx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
